// File: rtl/uart_v3_pkg.sv
// Shared encodings, FSM state types and helpers for the uart_v3 UART.
// Optional feature macro: UART_V3_MAJORITY_VOTE_EN (2-of-3 RX sample vote).
package uart_v3_pkg;

    localparam logic [1:0] ParNone  = 2'b00;
    localparam logic [1:0] ParOdd   = 2'b01;
    localparam logic [1:0] ParEven  = 2'b10;
    localparam logic [1:0] ParNone2 = 2'b11;

    localparam logic [1:0] Data5 = 2'b00;
    localparam logic [1:0] Data6 = 2'b01;
    localparam logic [1:0] Data7 = 2'b10;
    localparam logic [1:0] Data8 = 2'b11;

    typedef enum logic [2:0] {
        StRxIdle,
        StRxStart,
        StRxData,
        StRxParity,
        StRxStop,
        StRxWaitHigh
    } rx_state_e;

    typedef enum logic [2:0] {
        StTxIdle,
        StTxStart,
        StTxData,
        StTxParity,
        StTxStop
    } tx_state_e;

    function automatic int unsigned default_div(input int unsigned clock_rate,
                                                input int unsigned oversample,
                                                input int unsigned baud);
        return clock_rate / (oversample * baud);
    endfunction

    function automatic logic parity_en(input logic [1:0] par);
        return (par == ParOdd) || (par == ParEven);
    endfunction

    // Index of the final data bit for a cfg_data_bits encoding (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit(input logic [1:0] db);
        return 3'd4 + {1'b0, db};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] db);
        return 8'hff >> (2'd3 - db);
    endfunction

endpackage

// File: rtl/uart_v3_baud_gen.sv
// Oversample tick generator for uart_v3: free-running down-counter, runtime-loadable divider.
// Optional feature macro (consumed in uart_v3): UART_V3_MAJORITY_VOTE_EN.
module uart_v3_baud_gen
    import uart_v3_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned RESET_DIV = 108
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_clock_div,
    input  logic [DIV_WIDTH-1:0] user_clock_div,
    output logic                 tick,
    output logic [DIV_WIDTH-1:0] clock_div
);

    localparam logic [DIV_WIDTH-1:0] ResetDiv = DIV_WIDTH'(RESET_DIV);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // A divider of 0 behaves as 1: a tick on every clock.
    function automatic logic [DIV_WIDTH-1:0] reload(input logic [DIV_WIDTH-1:0] div);
        return (div == '0) ? '0 : div - 1'b1;
    endfunction

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (set_clock_div) begin
            div_d = user_clock_div;
            cnt_d = reload(user_clock_div);
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = reload(div_q);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= ResetDiv;
            cnt_q <= reload(ResetDiv);
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign clock_div = div_q;

endmodule

// File: rtl/uart_v3.sv
// UART with runtime frame format, oversampled RX, valid/ready TX and per-byte error flags.
// Define UART_V3_MAJORITY_VOTE_EN to take every RX sample as a 2-of-3 vote around mid-bit.
module uart_v3
    import uart_v3_pkg::*;
#(
    parameter int unsigned CLOCK_RATE       = 100000000,
    parameter int unsigned DEFAULT_BAUDRATE = 57600,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DIV_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [7:0]           tx_byte,
    output logic                 rx_valid,
    output logic [7:0]           rx_byte,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 is_receiving,
    output logic                 is_transmitting,
    input  logic [1:0]           cfg_data_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 set_clock_div,
    input  logic [DIV_WIDTH-1:0] user_clock_div,
    output logic [DIV_WIDTH-1:0] clock_div
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    // Tick counter value seen on the N-th tick of a bit is N-1.
`ifdef UART_V3_MAJORITY_VOTE_EN
    localparam logic [TickW-1:0] VoteA     = TickW'(OVERSAMPLE / 2 - 2);
    localparam logic [TickW-1:0] VoteB     = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] SampleCnt = TickW'(OVERSAMPLE / 2);
`else
    localparam logic [TickW-1:0] SampleCnt = TickW'(OVERSAMPLE / 2 - 1);
`endif

    logic tick;

    uart_v3_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH),
        .RESET_DIV (default_div(CLOCK_RATE, OVERSAMPLE, DEFAULT_BAUDRATE))
    ) u_baud_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_clock_div  (set_clock_div),
        .user_clock_div (user_clock_div),
        .tick           (tick),
        .clock_div      (clock_div)
    );

    // ---------------------------------------------------------------- RX
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_e        rx_state_q, rx_state_d;
    logic [TickW-1:0] rx_tick_q, rx_tick_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [1:0]       rx_db_q, rx_db_d;
    logic [1:0]       rx_par_q, rx_par_d;
    logic             rx_perr_q, rx_perr_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_parity_err_q, rx_parity_err_d;
    logic             rx_frame_err_q, rx_frame_err_d;
    logic             rx_sample_now;
    logic             rx_bit;

    assign rx_sample_now = tick && (rx_tick_q == SampleCnt);

`ifdef UART_V3_MAJORITY_VOTE_EN
    logic vote_a_q, vote_a_d, vote_b_q, vote_b_d;

    always_comb begin
        vote_a_d = vote_a_q;
        vote_b_d = vote_b_q;
        if (tick && rx_tick_q == VoteA) vote_a_d = rx_sync_q;
        if (tick && rx_tick_q == VoteB) vote_b_d = rx_sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_a_q <= 1'b1;
            vote_b_q <= 1'b1;
        end else begin
            vote_a_q <= vote_a_d;
            vote_b_q <= vote_b_d;
        end
    end

    assign rx_bit = (vote_a_q & vote_b_q) | (vote_a_q & rx_sync_q) | (vote_b_q & rx_sync_q);
`else
    assign rx_bit = rx_sync_q;
`endif

    always_comb begin
        rx_state_d      = rx_state_q;
        rx_tick_d       = rx_tick_q;
        rx_bit_d        = rx_bit_q;
        rx_shift_d      = rx_shift_q;
        rx_db_d         = rx_db_q;
        rx_par_d        = rx_par_q;
        rx_perr_d       = rx_perr_q;
        rx_valid_d      = 1'b0;
        rx_byte_d       = rx_byte_q;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;
        if (set_clock_div) begin
            rx_state_d = StRxIdle;
        end else begin
            if (rx_state_q != StRxIdle && tick) begin
                rx_tick_d = (rx_tick_q == TickLast) ? '0 : rx_tick_q + 1'b1;
            end
            unique case (rx_state_q)
                StRxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_d = StRxStart;
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_shift_d = '0;
                        rx_perr_d  = 1'b0;
                        rx_db_d    = cfg_data_bits;
                        rx_par_d   = cfg_parity;
                    end
                end
                StRxStart: begin
                    if (rx_sample_now) rx_state_d = rx_bit ? StRxIdle : StRxData;
                end
                StRxData: begin
                    if (rx_sample_now) begin
                        rx_shift_d[rx_bit_q] = rx_bit;
                        if (rx_bit_q == last_bit(rx_db_q)) begin
                            rx_state_d = parity_en(rx_par_q) ? StRxParity : StRxStop;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end
                end
                StRxParity: begin
                    if (rx_sample_now) begin
                        rx_perr_d  = rx_bit != (^rx_shift_q ^ (rx_par_q == ParOdd));
                        rx_state_d = StRxStop;
                    end
                end
                StRxStop: begin
                    if (rx_sample_now) begin
                        rx_valid_d      = 1'b1;
                        rx_byte_d       = rx_shift_q;
                        rx_parity_err_d = rx_perr_q;
                        rx_frame_err_d  = !rx_bit;
                        rx_state_d      = rx_bit ? StRxIdle : StRxWaitHigh;
                    end
                end
                StRxWaitHigh: begin
                    if (rx_sync_q) rx_state_d = StRxIdle;
                end
                default: rx_state_d = StRxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q      <= StRxIdle;
            rx_tick_q       <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            rx_db_q         <= Data8;
            rx_par_q        <= ParNone;
            rx_perr_q       <= 1'b0;
            rx_valid_q      <= 1'b0;
            rx_byte_q       <= '0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            rx_state_q      <= rx_state_d;
            rx_tick_q       <= rx_tick_d;
            rx_bit_q        <= rx_bit_d;
            rx_shift_q      <= rx_shift_d;
            rx_db_q         <= rx_db_d;
            rx_par_q        <= rx_par_d;
            rx_perr_q       <= rx_perr_d;
            rx_valid_q      <= rx_valid_d;
            rx_byte_q       <= rx_byte_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_byte       = rx_byte_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign is_receiving  = rx_state_q != StRxIdle;

    // ---------------------------------------------------------------- TX
    tx_state_e        tx_state_q, tx_state_d;
    logic [TickW-1:0] tx_tick_q, tx_tick_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [1:0]       tx_db_q, tx_db_d;
    logic [1:0]       tx_par_q, tx_par_d;
    logic             tx_st2_q, tx_st2_d;
    logic             tx_wait_q, tx_wait_d;
    logic             tx_line_q, tx_line_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_db_d    = tx_db_q;
        tx_par_d   = tx_par_q;
        tx_st2_d   = tx_st2_q;
        tx_wait_d  = tx_wait_q;
        tx_line_d  = tx_line_q;
        if (set_clock_div) begin
            tx_state_d = StTxIdle;
            tx_line_d  = 1'b1;
        end else if (tx_state_q == StTxIdle) begin
            if (tx_valid) begin
                tx_state_d = StTxStart;
                tx_data_d  = tx_byte & data_mask(cfg_data_bits);
                tx_db_d    = cfg_data_bits;
                tx_par_d   = cfg_parity;
                tx_st2_d   = cfg_stop2;
                tx_wait_d  = 1'b1;
                tx_tick_d  = '0;
                tx_bit_d   = '0;
            end
        end else if (tick) begin
            // The start bit is held back to the next tick so every bit spans whole ticks.
            if (tx_wait_q) begin
                tx_wait_d = 1'b0;
                tx_line_d = 1'b0;
                tx_tick_d = '0;
            end else if (tx_tick_q != TickLast) begin
                tx_tick_d = tx_tick_q + 1'b1;
            end else begin
                tx_tick_d = '0;
                case (tx_state_q)
                    StTxStart: begin
                        tx_state_d = StTxData;
                        tx_bit_d   = '0;
                        tx_line_d  = tx_data_q[0];
                    end
                    StTxData: begin
                        if (tx_bit_q == last_bit(tx_db_q)) begin
                            tx_bit_d = '0;
                            if (parity_en(tx_par_q)) begin
                                tx_state_d = StTxParity;
                                tx_line_d  = ^tx_data_q ^ (tx_par_q == ParOdd);
                            end else begin
                                tx_state_d = StTxStop;
                                tx_line_d  = 1'b1;
                            end
                        end else begin
                            tx_bit_d  = tx_bit_q + 3'd1;
                            tx_line_d = tx_data_q[tx_bit_q + 3'd1];
                        end
                    end
                    StTxParity: begin
                        tx_state_d = StTxStop;
                        tx_bit_d   = '0;
                        tx_line_d  = 1'b1;
                    end
                    StTxStop: begin
                        if (tx_st2_q && tx_bit_q == 3'd0) begin
                            tx_bit_d = 3'd1;
                        end else begin
                            tx_state_d = StTxIdle;
                        end
                    end
                    default: begin
                        tx_state_d = StTxIdle;
                        tx_line_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= StTxIdle;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            tx_db_q    <= Data8;
            tx_par_q   <= ParNone;
            tx_st2_q   <= 1'b0;
            tx_wait_q  <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            tx_db_q    <= tx_db_d;
            tx_par_q   <= tx_par_d;
            tx_st2_q   <= tx_st2_d;
            tx_wait_q  <= tx_wait_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign tx              = tx_line_q;
    assign tx_ready        = tx_state_q == StTxIdle;
    assign is_transmitting = tx_state_q != StTxIdle;

endmodule

// File: tb/tb_uart_v3.sv
// Self-checking bench for uart_v3: directed and randomized frames against a frame-level model.
// Build with UART_V3_MAJORITY_VOTE_EN to also exercise the RX sample vote.
module tb_uart_v3;

    localparam int DefDiv = 100000000 / (16 * 57600);
    localparam int BitClks = 64;

    logic        clk, rst_n, rx, tx, tx_valid, tx_ready, rx_valid;
    logic [7:0]  tx_byte, rx_byte;
    logic        rx_parity_err, rx_frame_err, is_receiving, is_transmitting;
    logic [1:0]  cfg_data_bits, cfg_parity;
    logic        cfg_stop2, set_clock_div;
    logic [15:0] user_clock_div, clock_div;
    logic        rx_line, loop_en;

    int n_checks = 0;
    int n_fail = 0;
    int rx_cnt = 0;

    logic fbits[16];
    int   flen;

    uart_v3 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .tx              (tx),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_byte         (tx_byte),
        .rx_valid        (rx_valid),
        .rx_byte         (rx_byte),
        .rx_parity_err   (rx_parity_err),
        .rx_frame_err    (rx_frame_err),
        .is_receiving    (is_receiving),
        .is_transmitting (is_transmitting),
        .cfg_data_bits   (cfg_data_bits),
        .cfg_parity      (cfg_parity),
        .cfg_stop2       (cfg_stop2),
        .set_clock_div   (set_clock_div),
        .user_clock_div  (user_clock_div),
        .clock_div       (clock_div)
    );

    assign rx = loop_en ? tx : rx_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rx_valid === 1'b1) rx_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial frame as seen on the wire: start, data LSB first, optional parity, stop bit(s).
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic [1:0] par, input logic st2);
        int n;
        logic p;
        n = 5 + int'(db);
        flen = 0;
        p = 1'b0;
        fbits[flen++] = 1'b0;
        for (int i = 0; i < n; i++) begin
            fbits[flen++] = d[i];
            p = p ^ d[i];
        end
        if (par == 2'b01) fbits[flen++] = ~p;
        if (par == 2'b10) fbits[flen++] = p;
        fbits[flen++] = 1'b1;
        if (st2) fbits[flen++] = 1'b1;
    endfunction

    function automatic int masked(input logic [7:0] d, input logic [1:0] db);
        return int'(d) & ((1 << (5 + int'(db))) - 1);
    endfunction

    task automatic load_div(input logic [15:0] v);
        @(negedge clk);
        user_clock_div = v;
        set_clock_div = 1'b1;
        @(negedge clk);
        set_clock_div = 1'b0;
    endtask

    task automatic wait_tx_low(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Loopback: check every TX bit at mid-bit, ready timing, and the byte received back.
    task automatic tx_frame(input string tag, input logic [7:0] d, input logic [1:0] db,
                            input logic [1:0] par, input logic st2);
        int base;
        bit found;
        build_frame(d, db, par, st2);
        loop_en = 1'b1;
        cfg_data_bits = db;
        cfg_parity = par;
        cfg_stop2 = st2;
        base = rx_cnt;
        @(negedge clk);
        tx_byte = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_byte = 8'($urandom);
        check({tag, "_ready_drop"}, 32'(tx_ready), 32'd0);
        wait_tx_low(found);
        check({tag, "_start_seen"}, 32'(found), 32'd1);
        if (found) begin
            repeat (BitClks / 2) @(negedge clk);
            cfg_data_bits = 2'($urandom);
            cfg_parity = 2'($urandom);
            cfg_stop2 = 1'($urandom);
            for (int i = 0; i < flen; i++) begin
                check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(fbits[i]));
                if (i < flen - 1) repeat (BitClks) @(negedge clk);
            end
            repeat (BitClks / 2 - 2) @(negedge clk);
            check({tag, "_busy_at_end"}, 32'(tx_ready), 32'd0);
            repeat (4) @(negedge clk);
            check({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
        end
        check({tag, "_rx_count"}, 32'(rx_cnt - base), 32'd1);
        check({tag, "_rx_byte"}, 32'(rx_byte), 32'(masked(d, db)));
        check({tag, "_rx_perr"}, 32'(rx_parity_err), 32'd0);
        check({tag, "_rx_ferr"}, 32'(rx_frame_err), 32'd0);
    endtask

    task automatic drive_bits();
        for (int i = 0; i < flen; i++) begin
            rx_line = fbits[i];
            repeat (BitClks) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] d, input logic [1:0] db,
                            input logic [1:0] par, input logic flip);
        int base;
        logic exp_perr;
        build_frame(d, db, par, 1'b0);
        exp_perr = flip && (par == 2'b01 || par == 2'b10);
        if (exp_perr) fbits[6 + int'(db)] = ~fbits[6 + int'(db)];
        loop_en = 1'b0;
        cfg_data_bits = db;
        cfg_parity = par;
        base = rx_cnt;
        drive_bits();
        repeat (4) @(negedge clk);
        check({tag, "_count"}, 32'(rx_cnt - base), 32'd1);
        check({tag, "_byte"}, 32'(rx_byte), 32'(masked(d, db)));
        check({tag, "_perr"}, 32'(rx_parity_err), 32'(exp_perr));
        check({tag, "_ferr"}, 32'(rx_frame_err), 32'd0);
    endtask

    initial begin
        int base;
        bit found;
        logic [7:0] d;
        rst_n = 1'b0;
        rx_line = 1'b1;
        loop_en = 1'b0;
        tx_valid = 1'b0;
        tx_byte = 8'h00;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        set_clock_div = 1'b0;
        user_clock_div = 16'd4;
        repeat (3) @(negedge clk);

        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_errs", 32'({rx_parity_err, rx_frame_err}), 32'd0);
        check("rst_busy", 32'({is_receiving, is_transmitting}), 32'd0);
        check("rst_clock_div", 32'(clock_div), 32'(DefDiv));
        rst_n = 1'b1;
        load_div(16'd4);
        check("div_loaded", 32'(clock_div), 32'd4);

        tx_frame("8n1_a5", 8'hA5, 2'b11, 2'b00, 1'b0);
        tx_frame("7e2_5a", 8'h5A, 2'b10, 2'b10, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tx_frame($sformatf("lb_rand%0d", k), 8'($urandom), 2'($urandom), 2'($urandom),
                     1'($urandom));
        end

        rx_frame("8o1_3c_flip", 8'h3C, 2'b11, 2'b01, 1'b1);
        repeat (200) @(negedge clk);
        check("perr_held", 32'(rx_parity_err), 32'd1);
        for (int k = 0; k < 4; k++) begin
            rx_frame($sformatf("rx_rand%0d", k), 8'($urandom), 2'($urandom), 2'($urandom),
                     1'($urandom));
        end

        // Stop bit low, then the line stays low for 20 bit times.
        d = 8'($urandom) | 8'h01;
        build_frame(d, 2'b11, 2'b00, 1'b0);
        fbits[flen - 1] = 1'b0;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        base = rx_cnt;
        for (int i = 0; i < flen; i++) begin
            rx_line = fbits[i];
            repeat (BitClks) @(negedge clk);
        end
        check("brk_count", 32'(rx_cnt - base), 32'd1);
        check("brk_ferr", 32'(rx_frame_err), 32'd1);
        check("brk_byte", 32'(rx_byte), 32'(d));
        check("brk_waiting", 32'(is_receiving), 32'd1);
        repeat (20 * BitClks) @(negedge clk);
        check("brk_no_more", 32'(rx_cnt - base), 32'd1);
        rx_line = 1'b1;
        repeat (BitClks) @(negedge clk);
        check("brk_idle", 32'(is_receiving), 32'd0);
        check("brk_after_high", 32'(rx_cnt - base), 32'd1);

        base = rx_cnt;
        rx_line = 1'b0;
        repeat (24) @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_idle", 32'(is_receiving), 32'd0);
        check("glitch_no_valid", 32'(rx_cnt - base), 32'd0);

`ifdef UART_V3_MAJORITY_VOTE_EN
        build_frame(8'h00, 2'b11, 2'b00, 1'b0);
        base = rx_cnt;
        for (int i = 0; i < flen; i++) begin
            rx_line = fbits[i];
            if (i == 4) begin
                repeat (BitClks / 2) @(negedge clk);
                rx_line = 1'b1;
                @(negedge clk);
                rx_line = 1'b0;
                repeat (BitClks / 2 - 1) @(negedge clk);
            end else begin
                repeat (BitClks) @(negedge clk);
            end
        end
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        check("vote_count", 32'(rx_cnt - base), 32'd1);
        check("vote_byte", 32'(rx_byte), 32'd0);
        check("vote_ferr", 32'(rx_frame_err), 32'd0);
`endif

        // Divider load in the middle of data bit 3 while the line is low.
        loop_en = 1'b1;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        base = rx_cnt;
        @(negedge clk);
        tx_byte = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_tx_low(found);
        check("abort_start_seen", 32'(found), 32'd1);
        repeat (BitClks / 2 + 4 * BitClks) @(negedge clk);
        check("abort_line_low", 32'(tx), 32'd0);
        user_clock_div = 16'd6;
        set_clock_div = 1'b1;
        @(negedge clk);
        set_clock_div = 1'b0;
        check("abort_tx_high", 32'(tx), 32'd1);
        check("abort_clock_div", 32'(clock_div), 32'd6);
        @(negedge clk);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        check("abort_idle", 32'({is_receiving, is_transmitting}), 32'd0);
        repeat (12 * BitClks) @(negedge clk);
        check("abort_no_rx", 32'(rx_cnt - base), 32'd0);
        load_div(16'd4);

        // Reset in the middle of an incoming frame.
        loop_en = 1'b0;
        build_frame(8'($urandom), 2'b11, 2'b00, 1'b0);
        base = rx_cnt;
        for (int i = 0; i < 4; i++) begin
            rx_line = fbits[i];
            repeat (BitClks) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        rx_line = 1'b1;
        #1;
        check("mid_rst_busy", 32'({is_receiving, is_transmitting}), 32'd0);
        check("mid_rst_byte", 32'(rx_byte), 32'd0);
        check("mid_rst_ferr", 32'(rx_frame_err), 32'd0);
        check("mid_rst_clock_div", 32'(clock_div), 32'(DefDiv));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load_div(16'd4);
        repeat (12 * BitClks) @(negedge clk);
        check("mid_rst_no_rx", 32'(rx_cnt - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
